// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and bit-time arithmetic.
// Used by both the transmitter and the receiver.
package uart_pkg;

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_START     = 3'd1,
      S_SEND_BYTE = 3'd2,
      S_PARITY    = 3'd3,
      S_STOP      = 3'd4
   } uart_state_t;

   // Clocks per serial bit; integer division truncates toward the faster rate.
   function automatic int unsigned calc_cycle(input int unsigned clk_fre_mhz,
                                              input int unsigned baud_rate);
      return (clk_fre_mhz * 32'd1000000) / baud_rate;
   endfunction

   function automatic logic even_parity(input logic [7:0] data);
      return ^data;
   endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-time counter: counts 0..CYCLE-1 and pulses bit_done on the last count.
// clear restarts the count from zero on the next edge.
module uart_baud_cnt #(
   parameter int unsigned CYCLE = 434
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   output logic bit_done
);

   localparam logic [15:0] LAST = 16'(CYCLE - 1);

   logic [15:0] cnt_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_reg <= '0;
      end else if (clear || (cnt_reg == LAST)) begin
         cnt_reg <= '0;
      end else begin
         cnt_reg <= cnt_reg + 16'd1;
      end
   end

   assign bit_done = (cnt_reg == LAST);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter, 8 data bits LSB first, one stop bit, valid/ready byte input.
// Define UART_TX_PARITY_EN to insert an even-parity bit between bit 7 and stop.
module uart_tx
   import uart_pkg::*;
#(
   parameter int unsigned CLK_FRE   = 50,
   parameter int unsigned BAUD_RATE = 115200
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] tx_data,
   input  logic       tx_data_valid,
   output logic       tx_data_ready,
   output logic       tx_pin
);

   localparam int unsigned CYCLE = calc_cycle(CLK_FRE, BAUD_RATE);

   uart_state_t state_reg, state_next;
   logic [2:0]  bit_cnt_reg, bit_cnt_next;
   logic [7:0]  data_reg, data_next;
   logic        ready_reg, ready_next;
   logic        pin_reg, pin_next;
   logic        bit_done;
   logic        clear;
   logic        accept;

   uart_baud_cnt #(
      .CYCLE(CYCLE)
   ) u_baud_cnt (
      .clk      (clk),
      .rst_n    (rst_n),
      .clear    (clear),
      .bit_done (bit_done)
   );

   assign accept = tx_data_valid && ready_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg   <= S_IDLE;
         bit_cnt_reg <= '0;
         data_reg    <= '0;
         ready_reg   <= 1'b0;
         pin_reg     <= 1'b1;
      end else begin
         state_reg   <= state_next;
         bit_cnt_reg <= bit_cnt_next;
         data_reg    <= data_next;
         ready_reg   <= ready_next;
         pin_reg     <= pin_next;
      end
   end

   always_comb begin
      state_next   = state_reg;
      bit_cnt_next = bit_cnt_reg;
      data_next    = data_reg;
      case (state_reg)
         S_IDLE: begin
            if (accept) begin
               state_next = S_START;
               data_next  = tx_data;
            end
         end
         S_START: begin
            if (bit_done) begin
               state_next = S_SEND_BYTE;
            end
         end
         S_SEND_BYTE: begin
            if (bit_done) begin
               // 3-bit counter wraps 7->0 as the byte completes
               bit_cnt_next = bit_cnt_reg + 3'd1;
               if (bit_cnt_reg == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                  state_next = S_PARITY;
`else
                  state_next = S_STOP;
`endif
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         S_PARITY: begin
            if (bit_done) begin
               state_next = S_STOP;
            end
         end
`endif
         S_STOP: begin
            if (bit_done) begin
               state_next = S_IDLE;
            end
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase
   end

   // Counter held at zero while idle and restarted on every state change.
   always_comb begin
      clear      = (state_next != state_reg) || (state_reg == S_IDLE);
      ready_next = (state_next == S_IDLE);
   end

   // Line level follows the current state, giving one clock of latency.
   always_comb begin
      pin_next = 1'b1;
      case (state_reg)
         S_START:     pin_next = 1'b0;
         S_SEND_BYTE: pin_next = data_reg[bit_cnt_reg];
`ifdef UART_TX_PARITY_EN
         S_PARITY:    pin_next = even_parity(data_reg);
`endif
         default:     pin_next = 1'b1;
      endcase
   end

   assign tx_data_ready = ready_reg;
   assign tx_pin        = pin_reg;

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx at 27 MHz / 115200 baud (234 clocks per bit).
module tb_uart_tx;

   localparam int C = 234;
`ifdef UART_TX_PARITY_EN
   localparam int NBITS = 11;
`else
   localparam int NBITS = 10;
`endif
   localparam int FLEN  = NBITS * C;
   localparam int BOUND = 4000;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic [7:0] tx_data = 8'h00;
   logic       tx_data_valid = 1'b0;
   logic       tx_data_ready;
   logic       tx_pin;

   int tests = 0;
   int fails = 0;
   int cyc = 0;

   logic [7:0] exp_q[$];
   int         hs_q[$];
   int         start_log[$];
   logic       samples [0:FLEN];
   int         idx = 0;
   bit         capturing = 1'b0;
   logic       prev = 1'b1;
   int         start_cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   uart_tx #(
      .CLK_FRE   (27),
      .BAUD_RATE (115200)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .tx_data       (tx_data),
      .tx_data_valid (tx_data_valid),
      .tx_data_ready (tx_data_ready),
      .tx_pin        (tx_pin)
   );

   // Every handshake edge defines one expected frame.
   always @(posedge clk) begin
      if (rst_n && tx_data_valid === 1'b1 && tx_data_ready === 1'b1) begin
         exp_q.push_back(tx_data);
         hs_q.push_back(cyc);
      end
   end

   // Reference line level for sample i of a frame carrying byte b.
   function automatic logic exp_level(input logic [7:0] b, input int i);
      int k;
      k = i / C;
      if (k == 0) return 1'b0;
      if (k <= 8) return b[k-1];
      if (k == 9 && NBITS == 11) return ^b;
      return 1'b1;
   endfunction

   task automatic check_frame();
      logic [7:0] b;
      logic [7:0] got;
      int bad;
      int hs;
      tests++;
      if (exp_q.size() == 0) begin
         fails++;
         $display("FAIL unexpected_frame: start bit at cycle %0d, required no frame", start_cyc);
         return;
      end
      b  = exp_q.pop_front();
      hs = hs_q.pop_front();
      bad = -1;
      for (int i = 0; i <= FLEN; i++) begin
         if (bad < 0 && samples[i] !== exp_level(b, i)) bad = i;
      end
      got = '0;
      for (int k = 0; k < 8; k++) got[k] = samples[(k+1)*C + C/2];
      if (bad >= 0) begin
         fails++;
         $display("FAIL frame: byte 0x%02h decoded 0x%02h, sample %0d (bit %0d) got %b required %b",
                  b, got, bad, bad / C, samples[bad], exp_level(b, bad));
      end else begin
         $display("[TB] frame 0x%02h ok, start cycle %0d", b, start_cyc);
      end
      tests++;
      if (start_cyc != hs + 2) begin
         fails++;
         $display("FAIL start_latency: first low sample at cycle %0d, required %0d", start_cyc, hs + 2);
      end
`ifdef UART_TX_PARITY_EN
      tests++;
      if (samples[9*C + C/2] !== ^b) begin
         fails++;
         $display("FAIL parity: byte 0x%02h parity %b, required %b", b, samples[9*C + C/2], ^b);
      end
`endif
   endtask

   // Monitor: samples the line once per clock on the falling edge.
   always @(negedge clk) begin
      if (!rst_n) begin
         tests++;
         if (tx_pin !== 1'b1) begin
            fails++;
            $display("FAIL reset_pin: tx_pin=%b during reset, required 1", tx_pin);
         end
         capturing = 1'b0;
         exp_q.delete();
         hs_q.delete();
         prev = 1'b1;
      end else begin
         if (capturing) begin
            samples[idx] = tx_pin;
            idx++;
            if (idx > FLEN) begin
               check_frame();
               capturing = 1'b0;
            end
         end else if (prev === 1'b1 && tx_pin === 1'b0) begin
            capturing  = 1'b1;
            samples[0] = 1'b0;
            idx        = 1;
            start_cyc  = cyc;
            start_log.push_back(cyc);
         end
         prev = tx_pin;
      end
   end

   task automatic send_byte(input logic [7:0] b, input bit hold);
      int n;
      n = 0;
      @(negedge clk);
      tx_data       = b;
      tx_data_valid = 1'b1;
      while (tx_data_ready !== 1'b1 && n < BOUND) begin
         @(negedge clk);
         n++;
      end
      tests++;
      if (n >= BOUND) begin
         fails++;
         $display("FAIL ready_timeout: byte 0x%02h waited %0d cycles, required ready", b, n);
         tx_data_valid = 1'b0;
         return;
      end
      @(negedge clk);
      if (!hold) tx_data_valid = 1'b0;
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      @(negedge clk);
      while ((capturing || exp_q.size() != 0 || tx_data_ready !== 1'b1) && n < BOUND) begin
         @(negedge clk);
         n++;
      end
      tests++;
      if (n >= BOUND) begin
         fails++;
         $display("FAIL done_timeout: %0d frames outstanding after %0d cycles, required 0", exp_q.size(), n);
      end
   endtask

   task automatic check_bit(input string name, input logic act, input logic req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %b, required %b", name, act, req);
      end
   endtask

   initial begin
      #1 rst_n = 1'b0;
      #1;
      check_bit("rst_pin", tx_pin, 1'b1);
      check_bit("rst_ready", tx_data_ready, 1'b0);
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b1;
      #1 check_bit("ready_before_edge", tx_data_ready, 1'b0);
      @(posedge clk);
      #1 check_bit("ready_first_edge", tx_data_ready, 1'b1);

      send_byte(8'h55, 1'b0);
      wait_done();

      // Back-to-back with valid held high.
      send_byte(8'hA5, 1'b1);
      tx_data = 8'h3C;
      send_byte(8'h3C, 1'b0);
      wait_done();
      tests++;
      if (start_log.size() < 2 || start_log[$] - start_log[$-1] != FLEN + 1) begin
         fails++;
         $display("FAIL b2b_period: start spacing %0d, required %0d",
                  (start_log.size() < 2) ? -1 : start_log[$] - start_log[$-1], FLEN + 1);
      end else begin
         $display("[TB] back-to-back spacing %0d", FLEN + 1);
      end

      // Data changes mid-frame are ignored; valid held into next ready sends them.
      send_byte(8'h0F, 1'b0);
      repeat (3*C) @(negedge clk);
      tx_data = 8'hFF;
      wait_done();
      send_byte(8'h0F, 1'b0);
      repeat (3*C) @(negedge clk);
      tx_data       = 8'hFF;
      tx_data_valid = 1'b1;
      send_byte(8'hFF, 1'b0);
      wait_done();

      send_byte(8'h07, 1'b0);
      wait_done();
      send_byte(8'h03, 1'b0);
      wait_done();

      for (int r = 0; r < 6; r++) begin
         repeat ($urandom_range(0, 40)) @(negedge clk);
         send_byte(8'($urandom), 1'b0);
         if ($urandom_range(0, 1) == 1) begin
            repeat (2*C) @(negedge clk);
            tx_data       = 8'($urandom);
            tx_data_valid = 1'b1;
            repeat ($urandom_range(1, 50)) @(negedge clk);
            tx_data_valid = 1'b0;
         end
         wait_done();
      end

      // Reset in the middle of bit 4 of 0xC3 (a low bit).
      send_byte(8'hC3, 1'b0);
      repeat (5*C + C/2) @(negedge clk);
      check_bit("bit4_low", tx_pin, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      check_bit("abort_pin", tx_pin, 1'b1);
      check_bit("abort_ready", tx_data_ready, 1'b0);
      repeat (8) @(negedge clk);
      #2 rst_n = 1'b1;
      #1 check_bit("ready_before_edge2", tx_data_ready, 1'b0);
      @(posedge clk);
      #1 check_bit("ready_first_edge2", tx_data_ready, 1'b1);
      send_byte(8'h81, 1'b0);
      wait_done();

      repeat (20) @(negedge clk);
      tests++;
      if (exp_q.size() != 0 || capturing) begin
         fails++;
         $display("FAIL drain: %0d frames outstanding, required 0", exp_q.size());
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #1500000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter CLK_FRE, default 50, meaning clock frequency in MHz.
REQ-002 SHALL have parameter BAUD_RATE, default 115200, meaning serial bit rate in bits/s.
REQ-003 SHALL have port clk  input  1  the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port tx_data  input  8  byte to transmit.
REQ-006 SHALL have port tx_data_valid  input  1  tx_data holds a byte to send.
REQ-007 SHALL have port tx_data_ready  output  1  block can accept a byte; registered.
REQ-008 SHALL have port tx_pin  output  1  serial line, idle high; registered.

Function
REQ-009 SHALL use CYCLE = CLK_FRE*1000000/BAUD_RATE (integer division) clocks per bit; legal range 2..65535 with a 16-bit bit-time counter.
REQ-010 SHALL implement states S_IDLE, S_START, S_SEND_BYTE, S_PARITY (macro only), S_STOP.
REQ-011 SHALL accept a byte only at a rising edge where tx_data_valid && tx_data_ready, latching tx_data internally at that edge.
REQ-012 SHALL keep tx_data_ready high in S_IDLE, low from the accepting edge until the cycle the FSM re-enters S_IDLE.
REQ-013 SHALL drive tx_pin low starting the clock after acceptance (one-clock latency), for exactly CYCLE clocks (S_START).
REQ-014 SHALL then send 8 data bits LSB first, each exactly CYCLE clocks, using a 3-bit bit counter wrapping 7->0 on exit to the next state.
REQ-015 SHALL then drive tx_pin high for exactly CYCLE clocks (S_STOP), then return to S_IDLE.
REQ-016 SHALL hold tx_pin high whenever in S_IDLE.
REQ-017 SHALL ignore tx_data and tx_data_valid while tx_data_ready is low; later input changes SHALL NOT alter the frame in flight.
REQ-018 SHALL support back-to-back frames: with tx_data_valid held high, the next start bit begins exactly 1 clock after S_IDLE re-entry, giving a frame period of 10*CYCLE+1 clocks (11*CYCLE+1 with parity).
REQ-019 SHALL reset the bit-time counter to 0 on every state transition and on each bit boundary.

Reset
REQ-020 SHALL, while rst_n low, force state S_IDLE, tx_pin=1, tx_data_ready=0, counters and latched byte 0.
REQ-021 SHALL assert tx_data_ready on the first rising edge after rst_n deasserts.
REQ-022 SHALL abort any frame in flight on reset, tx_pin going high immediately (asynchronous), with no partial frame resumed afterwards.

Configuration
REQ-023 SHALL, with UART_TX_PARITY_EN defined, insert one S_PARITY bit of CYCLE clocks between bit 7 and stop, value = XOR of the 8 data bits (even parity).
REQ-024 SHALL, without UART_TX_PARITY_EN, omit S_PARITY entirely, going directly from bit 7 to stop.

Structure
REQ-025 SHALL place state encodings and the CYCLE computation function in a shared package uart_pkg, used also by the receiver.
REQ-026 SHALL factor the bit-time counter into sub-module uart_baud_cnt (inputs clk, rst_n, clear; output bit_done pulse at count CYCLE-1).

Verification (CLK_FRE=27, BAUD_RATE=115200, CYCLE=234)
REQ-027 SHALL check reset: rst_n low -> tx_pin=1, tx_data_ready=0; first edge after release -> tx_data_ready=1.
REQ-028 SHALL send 0x55 -> tx_pin sequence 0,1,0,1,0,1,0,1,0,1, each level exactly 234 clocks, start one clock after handshake.
REQ-029 SHALL send 0xA5 then 0x3C with valid held high -> two correct frames, start bits 2341 clocks apart.
REQ-030 SHALL change tx_data to 0xFF mid-frame of 0x0F -> line still carries 0x0F; 0xFF sent only if valid remains high at next ready.
REQ-031 SHALL assert rst_n low at bit 4 of 0xC3 -> tx_pin=1 immediately, no further low bits, clean 0x81 frame after release.
REQ-032 SHALL, with UART_TX_PARITY_EN, send 0x07 -> parity bit 1 and 0x03 -> parity bit 0, each 234 clocks, before stop.
